secuenciador_isa: RTL and testbench

Multi-cycle instruction sequencer that drives the register-bank / ALU / RAM datapath. It fetches 20-bit instruction words from a synchronous instruction ROM, latches each one, and presents the decoded fields to the datapath in a fixed 4-cycle schedule. Write strobes for the bank and the RAM are confined to a single cycle per instruction. It sits between the instruction memory and the datapath and reports busy/done status and an executed-instruction count to the surrounding system.

---
 rtl/secuenciador_isa.sv | 170 +++++++++++++++++
 tb/tb_secuenciador_isa.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_isa.sv
// -----------------------------------------------------------------------------
// secuenciador_isa
//
// Multi-cycle instruction sequencer for the register-bank / ALU / RAM datapath.
// It fetches 20-bit words from a synchronous instruction ROM and latches each
// one into IR. It then presents the decoded fields to the datapath on a fixed
// four-cycle schedule: BUSQUEDA, CARGA, EJECUTA, ESCRIBE. Bank and RAM write
// strobes can be high only during ESCRIBE.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   start      : begin execution at pc_inicio (only honoured while idle)
//   pc_inicio  : first instruction address, captured with start
//   instr_dir  : instruction ROM address (always the program counter)
//   instr_lee  : ROM read enable, high only in BUSQUEDA
//   instr_dato : ROM data, valid the cycle after instr_lee
//   dl1, dl2   : bank read addresses, IR[19:15] and IR[14:10]
//   we_banco   : bank write strobe, IR[9] during ESCRIBE
//   aluop      : ALU operation, IR[8:6]
//   dir_ram    : RAM address, IR[5:1]
//   we_ram     : RAM write strobe, IR[0] during ESCRIBE
//   ocupado    : high whenever the sequencer is not idle
//   fin        : one-cycle pulse in the first idle cycle after a run ends
//   contador   : instructions executed since the last accepted start
// -----------------------------------------------------------------------------
module secuenciador_isa #(
  parameter int PC_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc_inicio,
  output logic [PC_W-1:0]  instr_dir,
  output logic             instr_lee,
  input  logic [19:0]      instr_dato,
  output logic [4:0]       dl1,
  output logic [4:0]       dl2,
  output logic             we_banco,
  output logic [2:0]       aluop,
  output logic [4:0]       dir_ram,
  output logic             we_ram,
  output logic             ocupado,
  output logic             fin,
  output logic [CNT_W-1:0] contador
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    BUSQUEDA = 3'd1,
    CARGA    = 3'd2,
    EJECUTA  = 3'd3,
    ESCRIBE  = 3'd4
  } estado_t;

  localparam logic [19:0]      HALT    = 20'hFFFFF;
  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic [PC_W-1:0]  r_pc;
  logic [19:0]      r_ir;
  logic [CNT_W-1:0] r_contador;
  logic             r_fin;

  logic             w_halt;
  logic             w_ultima;

  // The ROM word only matters in CARGA, which is the cycle after the read.
  assign w_halt   = (instr_dato == HALT);
  // The last ROM address ends the run. Execution never wraps back to 0.
  assign w_ultima = (r_pc == PC_MAX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment before the case keeps this purely
    // combinational; without it, any path that skips an assignment infers a
    // latch.
    w_estado_sig = r_estado;
    case (r_estado)
      REPOSO:   if (start) w_estado_sig = BUSQUEDA;
      BUSQUEDA: w_estado_sig = CARGA;
      CARGA:    w_estado_sig = w_halt ? REPOSO : EJECUTA;
      EJECUTA:  w_estado_sig = ESCRIBE;
      ESCRIBE:  w_estado_sig = w_ultima ? REPOSO : BUSQUEDA;
      default:  w_estado_sig = REPOSO;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program counter, instruction register, counter and end-of-run flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_contador <= '0;
      r_fin      <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (start) begin
            r_pc       <= pc_inicio;
            r_contador <= '0;
          end
        end
        CARGA: begin
          // A HALT word is not loaded, so the previous instruction stays
          // visible on the field outputs.
          if (w_halt) r_fin <= 1'b1;
          else        r_ir  <= instr_dato;
        end
        ESCRIBE: begin
          if (r_contador != CNT_MAX) r_contador <= r_contador + CNT_W'(1);
          if (w_ultima) r_fin <= 1'b1;
          else          r_pc  <= r_pc + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_lee = 1'b0;
    we_banco  = 1'b0;
    we_ram    = 1'b0;
    case (r_estado)
      BUSQUEDA: instr_lee = 1'b1;
      ESCRIBE: begin
        we_banco = r_ir[9];
        we_ram   = r_ir[0];
      end
      default: ;
    endcase
  end

  assign ocupado   = (r_estado != REPOSO);
  assign fin       = r_fin;
  assign contador  = r_contador;
  assign instr_dir = r_pc;

  // The fields come straight from IR. They are stable from EJECUTA onward and
  // hold while idle.
  assign dl1     = r_ir[19:15];
  assign dl2     = r_ir[14:10];
  assign aluop   = r_ir[8:6];
  assign dir_ram = r_ir[5:1];

endmodule

// File: tb/tb_secuenciador_isa.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_isa
//
// Bench for secuenciador_isa. A synchronous ROM model feeds the sequencer.
// For each run, a reference walk over the ROM pushes the expected fetch
// sequence into a queue. Every sampled cycle pops and compares fetches, checks
// the decoded fields in EJECUTA, and checks the strobe values in every cycle.
// -----------------------------------------------------------------------------
module tb_secuenciador_isa;

  localparam logic [19:0] HALT_W = 20'hFFFFF;

  typedef struct {
    logic [4:0]  addr;
    bit          halt;
    logic [19:0] instr;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  pc_inicio;
  logic [4:0]  instr_dir;
  logic        instr_lee;
  logic [19:0] instr_dato;
  logic [4:0]  dl1;
  logic [4:0]  dl2;
  logic        we_banco;
  logic [2:0]  aluop;
  logic [4:0]  dir_ram;
  logic        we_ram;
  logic        ocupado;
  logic        fin;
  logic [15:0] contador;

  logic [19:0] rom [32];

  int          n_run;
  int          n_fail;
  int          cyc;
  bit          mon_en;
  bit          active;
  int          phase;
  int          done_cnt;
  int          n_wb;
  int          n_wr;
  fetch_t      cur;
  fetch_t      fq[$];
  logic [19:0] model_ir;

  secuenciador_isa #(.PC_W(5), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc_inicio (pc_inicio),
    .instr_dir (instr_dir),
    .instr_lee (instr_lee),
    .instr_dato(instr_dato),
    .dl1       (dl1),
    .dl2       (dl2),
    .we_banco  (we_banco),
    .aluop     (aluop),
    .dir_ram   (dir_ram),
    .we_ram    (we_ram),
    .ocupado   (ocupado),
    .fin       (fin),
    .contador  (contador)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM: the data appears the cycle after the read.
  always @(posedge clk) begin
    if (instr_lee) instr_dato <= rom[instr_dir];
  end

  // Advance one cycle and check the sampled outputs against the scoreboard.
  task automatic step();
    logic exp_wb;
    logic exp_wr;
    @(negedge clk);
    cyc++;
    if (!mon_en) return;
    if (instr_lee === 1'b1) begin
      n_run++;
      if (fq.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_unexpected: instr_dir=%0d, none expected (cycle %0d)", instr_dir, cyc);
        active = 1'b0;
      end else begin
        cur    = fq.pop_front();
        active = 1'b1;
        phase  = 0;
        if (instr_dir !== cur.addr) begin
          n_fail++;
          $display("FAIL fetch_addr: instr_dir=%0d, expected %0d", instr_dir, cur.addr);
        end
      end
    end else if (active) begin
      phase++;
      if (phase > 4) active = 1'b0;
    end
    exp_wb = active && !cur.halt && (phase == 3) && cur.instr[9];
    exp_wr = active && !cur.halt && (phase == 3) && cur.instr[0];
    n_run++;
    if (we_banco !== exp_wb) begin
      n_fail++;
      $display("FAIL we_banco: got %b, expected %b (cycle %0d)", we_banco, exp_wb, cyc);
    end
    n_run++;
    if (we_ram !== exp_wr) begin
      n_fail++;
      $display("FAIL we_ram: got %b, expected %b (cycle %0d)", we_ram, exp_wr, cyc);
    end
    if (active && !cur.halt && phase == 2) begin
      n_run++;
      if ({dl1, dl2, aluop, dir_ram} !== {cur.instr[19:10], cur.instr[8:1]}) begin
        n_fail++;
        $display("FAIL fields: got dl1=%0d dl2=%0d aluop=%0d dir_ram=%0d, expected instr %05h",
                 dl1, dl2, aluop, dir_ram, cur.instr);
      end
    end
    if (active && !cur.halt && phase == 3) begin
      n_run++;
      if (contador !== 16'(done_cnt)) begin
        n_fail++;
        $display("FAIL contador_escribe: got %0d, expected %0d", contador, done_cnt);
      end
      done_cnt++;
    end
    if (we_banco === 1'b1) n_wb++;
    if (we_ram === 1'b1)   n_wr++;
  endtask

  // Reference walk over the ROM: push the expected fetches and tally the
  // expected strobes.
  task automatic model_prog(input logic [4:0] pc0, output int n_exec, output int e_wb,
                            output int e_wr, output bit halted);
    logic [4:0] a;
    fetch_t     e;
    a      = pc0;
    n_exec = 0;
    e_wb   = 0;
    e_wr   = 0;
    halted = 1'b0;
    for (int i = 0; i < 32; i++) begin
      e.addr  = a;
      e.instr = rom[a];
      e.halt  = (rom[a] == HALT_W);
      fq.push_back(e);
      if (e.halt) begin
        halted = 1'b1;
        break;
      end
      n_exec++;
      e_wb += int'(e.instr[9]);
      e_wr += int'(e.instr[0]);
      model_ir = e.instr;
      if (a == 5'd31) break;
      a = a + 5'd1;
    end
  endtask

  task automatic clear_model();
    fq.delete();
    active   = 1'b0;
    model_ir = '0;
  endtask

  // Run one program from pc0 and check its end of run. ign_at >= 0 pulses a
  // start with pc_inicio=10 at that loop index, which the DUT must ignore.
  // The task leaves rom_cnt/wb/wr results in its outputs for extra checks.
  task automatic run_prog(input logic [4:0] pc0, input int ign_at, input bit stop_at_fin,
                          output int got_cnt, output int got_wb, output int got_wr);
    int n_exec, e_wb, e_wr, k1, guard, exp_lat;
    bit halted;
    model_prog(pc0, n_exec, e_wb, e_wr, halted);
    n_wb      = 0;
    n_wr      = 0;
    done_cnt  = 0;
    start     = 1'b1;
    pc_inicio = pc0;
    step();
    start = 1'b0;
    k1    = cyc;
    n_run++;
    if (ocupado !== 1'b1 || contador !== 16'd0) begin
      n_fail++;
      $display("FAIL start_accept: ocupado=%b contador=%0d, expected 1 and 0", ocupado, contador);
    end
    guard = 0;
    while (fin !== 1'b1 && guard < 400) begin
      if (guard == ign_at) begin
        start     = 1'b1;
        pc_inicio = 5'd10;
      end
      step();
      start = 1'b0;
      guard++;
    end
    got_cnt = int'(contador);
    got_wb  = n_wb;
    got_wr  = n_wr;
    n_run++;
    if (guard >= 400) begin
      n_fail++;
      $display("FAIL fin_timeout: fin not seen within %0d cycles", guard);
    end else begin
      exp_lat = 4 * n_exec + (halted ? 2 : 0);
      n_run++;
      if (cyc - k1 !== exp_lat) begin
        n_fail++;
        $display("FAIL fin_latency: fin %0d cycles after first fetch, expected %0d", cyc - k1, exp_lat);
      end
      n_run++;
      if (ocupado !== 1'b0 || contador !== 16'(n_exec)) begin
        n_fail++;
        $display("FAIL fin_state: ocupado=%b contador=%0d, expected 0 and %0d", ocupado, contador, n_exec);
      end
      n_run++;
      if (fq.size() != 0 || n_wb != e_wb || n_wr != e_wr) begin
        n_fail++;
        $display("FAIL run_totals: pending=%0d wb=%0d wr=%0d, expected 0 %0d %0d",
                 fq.size(), n_wb, n_wr, e_wb, e_wr);
      end
      n_run++;
      if ({dl1, dl2, aluop, dir_ram} !== {model_ir[19:10], model_ir[8:1]}) begin
        n_fail++;
        $display("FAIL fields_hold: got dl1=%0d dl2=%0d aluop=%0d dir_ram=%0d, expected instr %05h",
                 dl1, dl2, aluop, dir_ram, model_ir);
      end
      if (!stop_at_fin) begin
        step();
        n_run++;
        if (fin !== 1'b0) begin
          n_fail++;
          $display("FAIL fin_width: fin=%b one cycle after pulse, expected 0", fin);
        end
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_run++;
    if ({instr_dir, instr_lee, dl1, dl2, we_banco, aluop, dir_ram, we_ram, ocupado, fin} !== '0
        || contador !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: dir=%0d lee=%b dl1=%0d dl2=%0d wb=%b alu=%0d ram=%0d wr=%b ocu=%b fin=%b cnt=%0d, expected all 0",
               tag, instr_dir, instr_lee, dl1, dl2, we_banco, aluop, dir_ram, we_ram, ocupado, fin, contador);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    step();
    step();
    check_idle_zero("reset_power_up");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 20'($urandom) & 20'hFFFFE;
    start     = 1'b1;
    pc_inicio = 5'($urandom_range(0, 20));
    step();
    start = 1'b0;
    repeat ($urandom_range(5, 20)) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_model();
    check_idle_zero("reset_mid_run");
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle_zero("reset_idle");
    end
  endtask

  task automatic test_single_halt();
    int c, wb, wr;
    clear_rom();
    rom[3] = 20'h08A41;
    rom[4] = HALT_W;
    run_prog(5'd3, -1, 1'b0, c, wb, wr);
    n_run++;
    if (c != 1 || wb != 1 || wr != 1 || dl1 !== 5'd1 || dl2 !== 5'd2 || aluop !== 3'd1 || dir_ram !== 5'd0) begin
      n_fail++;
      $display("FAIL single_halt: cnt=%0d wb=%0d wr=%0d dl1=%0d dl2=%0d alu=%0d ram=%0d, expected 1 1 1 1 2 1 0",
               c, wb, wr, dl1, dl2, aluop, dir_ram);
    end
  endtask

  task automatic test_strobe_gating();
    int c, wb, wr;
    clear_rom();
    rom[0] = 20'h12A00;
    rom[1] = 20'h0C0C1;
    rom[2] = 20'h7BDBE;
    rom[3] = HALT_W;
    run_prog(5'd0, -1, 1'b0, c, wb, wr);
    n_run++;
    if (c != 3 || wb != 1 || wr != 1) begin
      n_fail++;
      $display("FAIL strobe_gating: cnt=%0d wb=%0d wr=%0d, expected 3 1 1", c, wb, wr);
    end
  endtask

  task automatic test_ignored_start();
    int c, wb, wr;
    clear_rom();
    rom[0] = 20'h2B6C3;
    rom[1] = 20'h15A5A;
    rom[2] = 20'h3C201;
    rom[3] = HALT_W;
    rom[10] = 20'h00201;
    rom[11] = HALT_W;
    run_prog(5'd0, 5, 1'b0, c, wb, wr);
    n_run++;
    if (c != 3) begin
      n_fail++;
      $display("FAIL ignored_start: cnt=%0d, expected 3", c);
    end
  endtask

  task automatic test_end_of_memory();
    int c, wb, wr;
    clear_rom();
    rom[0]  = 20'h00201;
    rom[30] = 20'h4A8C1;
    rom[31] = 20'h0F27E;
    run_prog(5'd30, -1, 1'b0, c, wb, wr);
    n_run++;
    if (c != 2 || instr_dir !== 5'd31) begin
      n_fail++;
      $display("FAIL end_of_memory: cnt=%0d instr_dir=%0d, expected 2 and 31", c, instr_dir);
    end
    repeat (6) step();
  endtask

  task automatic test_back_to_back();
    int c, wb, wr;
    clear_rom();
    rom[5] = 20'h08A41;
    rom[6] = 20'h11111;
    rom[7] = HALT_W;
    rom[20] = 20'h20200;
    rom[21] = HALT_W;
    run_prog(5'd5, -1, 1'b1, c, wb, wr);
    run_prog(5'd20, -1, 1'b0, c, wb, wr);
    n_run++;
    if (c != 1 || wb != 1 || wr != 0) begin
      n_fail++;
      $display("FAIL back_to_back: cnt=%0d wb=%0d wr=%0d, expected 1 1 0", c, wb, wr);
    end
  endtask

  task automatic test_reset_mid_write();
    int n_exec, e_wb, e_wr, guard;
    bit halted;
    clear_rom();
    rom[0] = 20'h08A41;
    rom[1] = 20'h08A41;
    rom[2] = HALT_W;
    model_prog(5'd0, n_exec, e_wb, e_wr, halted);
    done_cnt  = 0;
    start     = 1'b1;
    pc_inicio = 5'd0;
    step();
    start = 1'b0;
    guard = 0;
    while (we_banco !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    n_run++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL rst_write_timeout: no ESCRIBE within %0d cycles", guard);
    end
    rst    = 1'b1;
    mon_en = 1'b0;
    step();
    rst = 1'b0;
    clear_model();
    check_idle_zero("rst_in_escribe");
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_run++;
      if (fin !== 1'b0 || ocupado !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_fin: fin=%b ocupado=%b, expected 0 0", fin, ocupado);
      end
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    active    = 1'b0;
    phase     = 0;
    done_cnt  = 0;
    model_ir  = '0;
    rst       = 1'b1;
    start     = 1'b0;
    pc_inicio = '0;
    clear_rom();
    test_reset();
    test_single_halt();
    test_strobe_gating();
    test_ignored_start();
    test_end_of_memory();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
